// File: rtl/mem_if_pkg.sv
// Shared definitions for the MEM-stage data port: responder FSM states,
// request encodings and byte-lane helpers used by both initiator and responder.
package mem_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic RW_READ   = 1'b0;
  localparam logic RW_WRITE  = 1'b1;
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  function automatic logic [1:0] lastBeatIdx(input logic size);
    return (size == SIZE_WORD) ? 2'd3 : 2'd0;
  endfunction

  // Big-endian: beat 0 of a word carries the MSB lane (3); bytes use lane 0.
  function automatic logic [1:0] laneOf(input logic size, input logic [1:0] cnt);
    return (size == SIZE_WORD) ? (2'd3 - cnt) : 2'd0;
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// DEPTH x 8 byte array: synchronous write, combinational read. Storage is
// never reset so contents survive a responder reset.
module mem_byte_array #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_wdata,
  output logic [7:0]        o_rdata
);

  logic [7:0] Mem [0:DEPTH-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      Mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = Mem[i_addr];

endmodule

// File: rtl/ram_req_responder.sv
// Byte-serial req/ack responder for the MEM-stage data port: byte and word
// accesses to a big-endian byte array, one byte per cycle.
module ram_req_responder
  import mem_if_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              R,
  input  logic              req,
  input  logic              RW,
  input  logic              Size,
  input  logic [ADDR_W-1:0] Addd,
  input  logic [31:0]       DI,
  output logic              ack,
  output logic              err,
  output logic              busy,
  output logic [31:0]       DO
);

  state_t r_state;
  state_t w_nextState;

  logic              r_rw;
  logic              r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_di;
  logic [1:0]        r_cnt;
  logic              r_ack;
  logic              r_err;
  logic              r_busy;
  logic [31:0]       r_do;

  logic              w_misaligned;
  logic              w_lastBeat;
  logic              w_accept;
  logic              w_beat;
  logic              w_we;
  logic [ADDR_W-1:0] w_beatAddr;
  logic [1:0]        w_lane;
  logic [7:0]        w_wbyte;
  logic [7:0]        w_rbyte;

  assign w_misaligned = (Size == SIZE_WORD) && (Addd[1:0] != 2'b00);
  assign w_lastBeat   = (r_cnt == lastBeatIdx(r_size));
  assign w_beatAddr   = r_addr + ADDR_W'(r_cnt);
  assign w_lane       = laneOf(r_size, r_cnt);
  assign w_wbyte      = r_di[8*w_lane +: 8];
  assign w_we         = w_beat && (r_rw == RW_WRITE);

  mem_byte_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_addr  (w_beatAddr),
    .i_wdata (w_wbyte),
    .o_rdata (w_rbyte)
  );

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_beat      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_accept    = 1'b1;
          w_nextState = w_misaligned ? ST_RESP : ST_XFER;
        end
      end
      ST_XFER: begin
        w_beat = 1'b1;
        if (w_lastBeat) begin
          w_nextState = ST_RESP;
        end
      end
      ST_RESP: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_rw   <= RW_READ;
      r_size <= SIZE_BYTE;
      r_addr <= '0;
      r_di   <= '0;
      r_cnt  <= '0;
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_busy <= 1'b0;
      r_do   <= '0;
    end else begin
      r_ack  <= (w_nextState == ST_RESP);
      r_err  <= w_accept && w_misaligned;
      r_busy <= (w_nextState != ST_IDLE);
      if (w_accept) begin
        r_rw   <= RW;
        r_size <= Size;
        r_addr <= Addd;
        r_di   <= DI;
        r_cnt  <= '0;
      end
      if (w_beat) begin
        r_cnt <= r_cnt + 2'd1;
        if (r_rw == RW_READ) begin
          if (r_size == SIZE_BYTE) begin
            r_do <= {24'b0, w_rbyte};
          end else begin
            r_do[8*w_lane +: 8] <= w_rbyte;
          end
        end
      end
    end
  end

  assign ack  = r_ack;
  assign err  = r_err;
  assign busy = r_busy;
  assign DO   = r_do;

endmodule

// File: tb/tb_ram_req_responder.sv
// Directed self-checking bench for ram_req_responder: latency, busy window,
// big-endian data, misaligned requests and reset abort during a word write.
module tb_ram_req_responder;
  import mem_if_pkg::*;

  logic        clk  = 1'b0;
  logic        R    = 1'b0;
  logic        req  = 1'b0;
  logic        RW   = 1'b0;
  logic        Size = 1'b0;
  logic [7:0]  Addd = 8'h00;
  logic [31:0] DI   = 32'h0;
  logic        ack;
  logic        err;
  logic        busy;
  logic [31:0] DO;

  int checks = 0;
  int errors = 0;

  int          lat;
  logic [31:0] dout;
  logic        e;
  logic [7:0]  bm;
  int          ackSeen;

  always #5 clk = ~clk;

  ram_req_responder #(
    .DEPTH  (256),
    .ADDR_W (8)
  ) dut (
    .clk  (clk),
    .R    (R),
    .req  (req),
    .RW   (RW),
    .Size (Size),
    .Addd (Addd),
    .DI   (DI),
    .ack  (ack),
    .err  (err),
    .busy (busy),
    .DO   (DO)
  );

  function automatic logic [31:0] memWord(input int a);
    return {dut.u_array.Mem[a], dut.u_array.Mem[a+1],
            dut.u_array.Mem[a+2], dut.u_array.Mem[a+3]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full request; busyMask bit k is busy sampled in cycle N+k (bit 0 = cycle N).
  task automatic applyStimulus(input logic rw, input logic size, input logic [7:0] addr,
                               input logic [31:0] di, output int latency,
                               output logic [31:0] rdata, output logic errOut,
                               output logic [7:0] busyMask);
    @(negedge clk);
    RW = rw; Size = size; Addd = addr; DI = di; req = 1'b1;
    latency = 0; rdata = 32'h0; errOut = 1'b0; busyMask = 8'h0;
    busyMask[0] = busy;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i < 8) busyMask[3'(i)] = busy;
      if (ack) begin
        latency = i; rdata = DO; errOut = err; req = 1'b0;
        break;
      end
      if (i == 1) begin
        Addd = ~addr; DI = ~di;
      end
    end
    req = 1'b0;
    if (latency != 0 && latency < 7) begin
      @(posedge clk);
      #1;
      busyMask[3'(latency + 1)] = busy;
    end
  endtask

  logic [7:0] preAddr [0:6] = '{8'd56, 8'd57, 8'd59, 8'd16, 8'd17, 8'd18, 8'd19};
  logic [7:0] preData [0:6] = '{8'h07, 8'h11, 8'h22, 8'h30, 8'h31, 8'h32, 8'h33};

  initial begin
    #12;
    checkOutput("rst_ack", 32'(ack), 32'h0);
    checkOutput("rst_err", 32'(err), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_do", DO, 32'h0);
    @(negedge clk);
    R = 1'b1;

    applyStimulus(RW_WRITE, SIZE_WORD, 8'd52, 32'hFFFF_FFFE, lat, dout, e, bm);
    checkOutput("pre52_lat", 32'(lat), 32'd5);
    for (int k = 0; k < 7; k++) begin
      applyStimulus(RW_WRITE, SIZE_BYTE, preAddr[k], {24'h0, preData[k]}, lat, dout, e, bm);
      checkOutput("pre_byte_lat", 32'(lat), 32'd2);
    end

    applyStimulus(RW_READ, SIZE_WORD, 8'd52, 32'h0, lat, dout, e, bm);
    checkOutput("t1_lat", 32'(lat), 32'd5);
    checkOutput("t1_do", dout, 32'hFFFF_FFFE);
    checkOutput("t1_err", 32'(e), 32'h0);
    checkOutput("t1_busy", 32'(bm), 32'h3E);

    applyStimulus(RW_READ, SIZE_BYTE, 8'd56, 32'h0, lat, dout, e, bm);
    checkOutput("t2_lat", 32'(lat), 32'd2);
    checkOutput("t2_do", dout, 32'h0000_0007);
    checkOutput("t2_busy", 32'(bm), 32'h06);

    applyStimulus(RW_WRITE, SIZE_WORD, 8'd8, 32'hA1B2_C3D4, lat, dout, e, bm);
    checkOutput("t3_wlat", 32'(lat), 32'd5);
    checkOutput("t3_mem", memWord(8), 32'hA1B2_C3D4);
    applyStimulus(RW_READ, SIZE_WORD, 8'd8, 32'h0, lat, dout, e, bm);
    checkOutput("t3_do", dout, 32'hA1B2_C3D4);

    applyStimulus(RW_WRITE, SIZE_WORD, 8'd9, 32'h0, lat, dout, e, bm);
    checkOutput("mis_w_lat", 32'(lat), 32'd1);
    checkOutput("mis_w_err", 32'(e), 32'h1);
    checkOutput("mis_w_mem", memWord(8), 32'hA1B2_C3D4);

    applyStimulus(RW_WRITE, SIZE_BYTE, 8'd58, 32'h1234_5658, lat, dout, e, bm);
    checkOutput("t4_lat", 32'(lat), 32'd2);
    checkOutput("t4_mem58", 32'(dut.u_array.Mem[58]), 32'h58);
    checkOutput("t4_mem57", 32'(dut.u_array.Mem[57]), 32'h11);
    checkOutput("t4_mem59", 32'(dut.u_array.Mem[59]), 32'h22);

    applyStimulus(RW_WRITE, SIZE_BYTE, 8'd255, 32'h0000_005A, lat, dout, e, bm);
    applyStimulus(RW_READ, SIZE_BYTE, 8'd255, 32'h0, lat, dout, e, bm);
    checkOutput("top_do", dout, 32'h0000_005A);

    @(negedge clk);
    RW = RW_WRITE; Size = SIZE_WORD; Addd = 8'd16; DI = 32'hDEAD_BEEF; req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    R = 1'b0;
    #1;
    checkOutput("t6_ack", 32'(ack), 32'h0);
    checkOutput("t6_err", 32'(err), 32'h0);
    checkOutput("t6_busy", 32'(busy), 32'h0);
    checkOutput("t6_do", DO, 32'h0);
    ackSeen = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (ack) ackSeen++;
    end
    @(negedge clk);
    R = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (ack) ackSeen++;
    end
    checkOutput("t6_noack", 32'(ackSeen), 32'h0);
    checkOutput("t6_idle", 32'(busy), 32'h0);
    checkOutput("t6_mem", memWord(16), 32'hDE31_3233);

    applyStimulus(RW_READ, SIZE_WORD, 8'd53, 32'h0, lat, dout, e, bm);
    checkOutput("t5_lat", 32'(lat), 32'd1);
    checkOutput("t5_err", 32'(e), 32'h1);
    checkOutput("t5_do", dout, 32'h0);
    checkOutput("t5_busy", 32'(bm), 32'h02);
    checkOutput("t5_mem", memWord(52), 32'hFFFF_FFFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
